tnn_sample_sched: RTL and testbench



---
 rtl/tnn_pkg.sv | 20 ++
 rtl/tnn_sat_counter.sv | 33 +++
 rtl/tnn_sample_sched.sv | 155 +++++++++++++++
 tb/tb_tnn_sample_sched.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tnn_pkg.sv
// Shared types and helpers for the tnn classifier sample sequencer.
package tnn_pkg;

  localparam int DEF_NUM_FEAT = 7;
  localparam int DEF_FEAT_W   = 2;
  localparam int CORE_LAT_MAX = 15;
  localparam int SETTLE_W     = 4;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SETTLE  = 2'd1,
    HOLD    = 2'd2
  } state_e;

  // LSB position of feature slot idx inside the packed core input vector.
  function automatic int unsigned slot_lsb(input int unsigned idx, input int unsigned feat_w);
    return idx * feat_w;
  endfunction

endpackage

// File: rtl/tnn_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module tnn_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] q_r;

  // Count register: clear wins, then saturating increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= CNT_ZERO;
    end else if (clr) begin
      q_r <= CNT_ZERO;
    end else if (inc && (q_r != CNT_MAX)) begin
      q_r <= q_r + CNT_ONE;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/tnn_sample_sched.sv
// Feature-packing sequencer for a combinational evolved classifier core:
// collects one feature per beat, waits CORE_LAT settle cycles, returns the class bit.
module tnn_sample_sched
  import tnn_pkg::*;
#(
  parameter int NUM_FEAT = DEF_NUM_FEAT,
  parameter int FEAT_W   = DEF_FEAT_W,
  parameter int CORE_LAT = 0,
  parameter int CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       feat_valid,
  output logic                       feat_ready,
  input  logic [FEAT_W-1:0]          feat_data,
  output logic [NUM_FEAT*FEAT_W-1:0] core_in,
  input  logic                       core_out,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic                       res_class,
  input  logic                       flush,
  input  logic                       stat_clr,
  output logic [CNT_W-1:0]           cnt_total,
  output logic [CNT_W-1:0]           cnt_pos
);

  localparam int IN_W   = NUM_FEAT * FEAT_W;
  localparam int IDX_W  = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
  localparam int SLOT_W = (IN_W > 1) ? $clog2(IN_W) : 1;

  localparam logic [IDX_W-1:0]    IDX_ZERO    = IDX_W'(0);
  localparam logic [IDX_W-1:0]    IDX_ONE     = IDX_W'(1);
  localparam logic [IDX_W-1:0]    LAST_IDX    = IDX_W'(NUM_FEAT - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_ZERO = SETTLE_W'(0);
  localparam logic [SETTLE_W-1:0] SETTLE_ONE  = SETTLE_W'(1);
  localparam logic [SETTLE_W-1:0] LAT_INIT    = SETTLE_W'(CORE_LAT);

  if ((CORE_LAT < 0) || (CORE_LAT > CORE_LAT_MAX)) begin : g_core_lat_range
    $error("tnn_sample_sched: CORE_LAT must be within 0..15");
  end

  state_e               state_r, state_s;
  logic [IDX_W-1:0]     idx_r, idx_s;
  logic [SETTLE_W-1:0]  settle_r, settle_s;
  logic [IN_W-1:0]      core_in_r, core_in_s;
  logic                 res_valid_r, res_valid_s;
  logic                 res_class_r, res_class_s;
  logic                 feat_ready_r, feat_ready_s;
  logic [SLOT_W-1:0]    slot_s;
  logic                 hs_s;
  logic                 hs_pos_s;

  assign slot_s   = SLOT_W'(slot_lsb(32'(idx_r), FEAT_W));
  // A result handshake that collides with flush is dropped, not counted.
  assign hs_s     = res_valid_r & res_ready & ~flush;
  assign hs_pos_s = hs_s & res_class_r;

  // Next-state, packing and capture logic.
  always_comb begin
    state_s      = state_r;
    idx_s        = idx_r;
    settle_s     = settle_r;
    core_in_s    = core_in_r;
    res_valid_s  = res_valid_r;
    res_class_s  = res_class_r;
    if (flush) begin
      state_s     = COLLECT;
      idx_s       = IDX_ZERO;
      res_valid_s = 1'b0;
    end else begin
      case (state_r)
        COLLECT: begin
          if (feat_valid) begin
            core_in_s[slot_s +: FEAT_W] = feat_data;
            if (idx_r == LAST_IDX) begin
              idx_s    = IDX_ZERO;
              settle_s = LAT_INIT;
              state_s  = SETTLE;
            end else begin
              idx_s = idx_r + IDX_ONE;
            end
          end else begin
            idx_s = idx_r;
          end
        end
        SETTLE: begin
          if (settle_r == SETTLE_ZERO) begin
            res_class_s = core_out;
            res_valid_s = 1'b1;
            state_s     = HOLD;
          end else begin
            settle_s = settle_r - SETTLE_ONE;
          end
        end
        HOLD: begin
          if (res_ready) begin
            res_valid_s = 1'b0;
            state_s     = COLLECT;
          end else begin
            state_s = HOLD;
          end
        end
        default: begin
          state_s     = COLLECT;
          idx_s       = IDX_ZERO;
          res_valid_s = 1'b0;
        end
      endcase
    end
    feat_ready_s = (state_s == COLLECT);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= COLLECT;
      idx_r        <= IDX_ZERO;
      settle_r     <= SETTLE_ZERO;
      core_in_r    <= {IN_W{1'b0}};
      res_valid_r  <= 1'b0;
      res_class_r  <= 1'b0;
      feat_ready_r <= 1'b1;
    end else begin
      state_r      <= state_s;
      idx_r        <= idx_s;
      settle_r     <= settle_s;
      core_in_r    <= core_in_s;
      res_valid_r  <= res_valid_s;
      res_class_r  <= res_class_s;
      feat_ready_r <= feat_ready_s;
    end
  end

  assign feat_ready = feat_ready_r;
  assign core_in    = core_in_r;
  assign res_valid  = res_valid_r;
  assign res_class  = res_class_r;

  tnn_sat_counter #(.CNT_W(CNT_W)) u_cnt_total (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hs_s),
    .clr   (stat_clr),
    .q     (cnt_total)
  );

  tnn_sat_counter #(.CNT_W(CNT_W)) u_cnt_pos (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hs_pos_s),
    .clr   (stat_clr),
    .q     (cnt_pos)
  );

endmodule

// File: tb/tb_tnn_sample_sched.sv
// Bench for tnn_sample_sched: three instances (CORE_LAT 0, CORE_LAT 3, CNT_W 2) share stimulus,
// each checked every cycle against a timestamp-based model, plus directed literal checks.
module tb_tnn_sample_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       feat_valid = 1'b0;
  logic [1:0] feat_data = 2'd0;
  logic       res_ready = 1'b0;
  logic       flush = 1'b0;
  logic       stat_clr = 1'b0;
  bit         chk_en = 1'b0;

  logic [2:0]  feat_ready_w, res_valid_w, res_class_w, core_out_w;
  logic [13:0] core_in_w [3];
  logic [15:0] tot_w [3];
  logic [15:0] pos_w [3];
  logic [15:0] tot0, pos0, tot1, pos1;
  logic [1:0]  tot2, pos2;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  assign core_out_w[0] = core_in_w[0][13];
  assign core_out_w[1] = core_in_w[1][13];
  assign core_out_w[2] = core_in_w[2][13];
  assign tot_w[0] = tot0;
  assign pos_w[0] = pos0;
  assign tot_w[1] = tot1;
  assign pos_w[1] = pos1;
  assign tot_w[2] = {14'd0, tot2};
  assign pos_w[2] = {14'd0, pos2};

  tnn_sample_sched #(.NUM_FEAT(7), .FEAT_W(2), .CORE_LAT(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .feat_valid(feat_valid), .feat_ready(feat_ready_w[0]),
    .feat_data(feat_data), .core_in(core_in_w[0]), .core_out(core_out_w[0]),
    .res_valid(res_valid_w[0]), .res_ready(res_ready), .res_class(res_class_w[0]),
    .flush(flush), .stat_clr(stat_clr), .cnt_total(tot0), .cnt_pos(pos0));

  tnn_sample_sched #(.NUM_FEAT(7), .FEAT_W(2), .CORE_LAT(3), .CNT_W(16)) dut3 (
    .clk(clk), .rst_n(rst_n), .feat_valid(feat_valid), .feat_ready(feat_ready_w[1]),
    .feat_data(feat_data), .core_in(core_in_w[1]), .core_out(core_out_w[1]),
    .res_valid(res_valid_w[1]), .res_ready(res_ready), .res_class(res_class_w[1]),
    .flush(flush), .stat_clr(stat_clr), .cnt_total(tot1), .cnt_pos(pos1));

  tnn_sample_sched #(.NUM_FEAT(7), .FEAT_W(2), .CORE_LAT(0), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .feat_valid(feat_valid), .feat_ready(feat_ready_w[2]),
    .feat_data(feat_data), .core_in(core_in_w[2]), .core_out(core_out_w[2]),
    .res_valid(res_valid_w[2]), .res_ready(res_ready), .res_class(res_class_w[2]),
    .flush(flush), .stat_clr(stat_clr), .cnt_total(tot2), .cnt_pos(pos2));

  // Reference model: a sample is a 14-bit vector filled slot by slot; once full the
  // instance is busy and the result is visible from 2+LAT cycles after the last beat.
  int          cyc = 0;
  logic [13:0] m_vec [3] = '{14'd0, 14'd0, 14'd0};
  int          m_n [3] = '{0, 0, 0};
  bit          m_busy [3] = '{1'b0, 1'b0, 1'b0};
  int          m_tlast [3] = '{0, 0, 0};
  int          m_tot [3] = '{0, 0, 0};
  int          m_pos [3] = '{0, 0, 0};

  function automatic int lat_of(input int k);
    return (k == 1) ? 3 : 0;
  endfunction

  function automatic int max_of(input int k);
    return (k == 2) ? 3 : 65535;
  endfunction

  function automatic bit exp_valid(input int k);
    return m_busy[k] && (cyc >= m_tlast[k] + 2 + lat_of(k));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin : model_upd
    bit          hs;
    int          tot;
    int          pos;
    logic [13:0] vec;
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        m_vec[k]   <= 14'd0;
        m_n[k]     <= 0;
        m_busy[k]  <= 1'b0;
        m_tlast[k] <= 0;
        m_tot[k]   <= 0;
        m_pos[k]   <= 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        hs  = exp_valid(k) && res_ready && !flush;
        tot = m_tot[k];
        pos = m_pos[k];
        if (stat_clr) begin
          tot = 0;
          pos = 0;
        end else if (hs) begin
          tot = (tot < max_of(k)) ? tot + 1 : tot;
          if (m_vec[k][13]) pos = (pos < max_of(k)) ? pos + 1 : pos;
        end
        m_tot[k] <= tot;
        m_pos[k] <= pos;
        if (flush) begin
          m_busy[k] <= 1'b0;
          m_n[k]    <= 0;
        end else if (!m_busy[k] && feat_valid) begin
          vec = m_vec[k];
          vec[2*m_n[k] +: 2] = feat_data;
          m_vec[k] <= vec;
          if (m_n[k] == 6) begin
            m_n[k]     <= 0;
            m_busy[k]  <= 1'b1;
            m_tlast[k] <= cyc;
          end else begin
            m_n[k] <= m_n[k] + 1;
          end
        end else if (hs) begin
          m_busy[k] <= 1'b0;
        end
      end
      cyc <= cyc + 1;
    end
  end

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("d%0d_feat_ready c%0d", k, cyc), int'(feat_ready_w[k]), int'(!m_busy[k]));
        chk($sformatf("d%0d_res_valid c%0d", k, cyc), int'(res_valid_w[k]), int'(exp_valid(k)));
        if (exp_valid(k))
          chk($sformatf("d%0d_res_class c%0d", k, cyc), int'(res_class_w[k]), int'(m_vec[k][13]));
        chk($sformatf("d%0d_core_in c%0d", k, cyc), int'(core_in_w[k]), int'(m_vec[k]));
        chk($sformatf("d%0d_cnt_total c%0d", k, cyc), int'(tot_w[k]), m_tot[k]);
        chk($sformatf("d%0d_cnt_pos c%0d", k, cyc), int'(pos_w[k]), m_pos[k]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic send_sample(input logic [13:0] v);
    for (int i = 0; i < 7; i++) begin
      feat_valid = 1'b1;
      feat_data  = v[2*i +: 2];
      tick();
    end
    feat_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if ((&feat_ready_w) && !(|res_valid_w)) break;
      tick();
    end
    chk("wait_idle_reached", int'((&feat_ready_w) && !(|res_valid_w)), 1);
  endtask

  task automatic wait_all_valid();
    for (int i = 0; i < 60; i++) begin
      if (&res_valid_w) break;
      tick();
    end
    chk("wait_valid_reached", int'(&res_valid_w), 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    rst_n  = 1'b1;

    // Reset values.
    at_neg();
    chk("rst_feat_ready", int'(feat_ready_w[0]), 1);
    chk("rst_res_valid", int'(res_valid_w[0]), 0);
    chk("rst_core_in", int'(core_in_w[0]), 0);
    chk("rst_cnt_total", int'(tot0), 0);

    // Packing and class, CORE_LAT 0.
    res_ready = 1'b1;
    send_sample(14'h2093);
    at_neg();
    chk("pack_valid_t1", int'(res_valid_w[0]), 0);
    tick();
    at_neg();
    chk("pack_valid_t2", int'(res_valid_w[0]), 1);
    chk("pack_class", int'(res_class_w[0]), 1);
    chk("pack_core_in", int'(core_in_w[0]), 16'h2093);
    tick();
    at_neg();
    chk("pack_cnt_total", int'(tot0), 1);
    chk("pack_cnt_pos", int'(pos0), 1);
    chk("pack_ready_after", int'(feat_ready_w[0]), 1);

    // Backpressure: five cycles of res_ready low while the result is held.
    wait_idle();
    res_ready = 1'b0;
    send_sample(14'h2093);
    tick();
    for (int i = 0; i < 5; i++) begin
      at_neg();
      chk("bp_valid_held", int'(res_valid_w[0]), 1);
      chk("bp_class_stable", int'(res_class_w[0]), 1);
      chk("bp_ready_low", int'(feat_ready_w[0]), 0);
      tick();
    end
    res_ready = 1'b1;
    at_neg();
    chk("bp_valid_6th", int'(res_valid_w[0]), 1);
    tick();
    at_neg();
    chk("bp_ready_after", int'(feat_ready_w[0]), 1);
    chk("bp_cnt_total", int'(tot0), 2);

    // Latency with CORE_LAT 3.
    wait_idle();
    send_sample(14'h3939);
    for (int i = 1; i < 5; i++) begin
      at_neg();
      chk("lat3_not_valid", int'(res_valid_w[1]), 0);
      chk("lat3_core_in_stable", int'(core_in_w[1]), 16'h3939);
      tick();
    end
    at_neg();
    chk("lat3_valid_t5", int'(res_valid_w[1]), 1);
    chk("lat3_class", int'(res_class_w[1]), 1);

    // Flush after four beats; the coincident beat is discarded and core_in is kept.
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      feat_valid = 1'b1;
      feat_data  = 2'd3;
      tick();
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    feat_valid = 1'b0;
    at_neg();
    chk("flush_core_in_kept", int'(core_in_w[0]), 16'h39FF);
    chk("flush_ready", int'(feat_ready_w[0]), 1);
    send_sample(14'h0000);
    wait_idle();
    chk("flush_core_in_new", int'(core_in_w[0]), 0);
    chk("flush_cnt_total", int'(tot0), 4);
    chk("flush_cnt_pos", int'(pos0), 3);

    // Saturation with a 2-bit counter, then clear coincident with a handshake.
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    at_neg();
    chk("clr_cnt_total", int'(tot2), 0);
    for (int s = 0; s < 5; s++) begin
      send_sample(14'h2093);
      wait_idle();
    end
    chk("sat_cnt_total", int'(tot2), 3);
    chk("sat_cnt_pos", int'(pos2), 3);
    chk("sat_wide_total", int'(tot0), 5);
    res_ready = 1'b0;
    send_sample(14'h3939);
    wait_all_valid();
    stat_clr  = 1'b1;
    res_ready = 1'b1;
    tick();
    stat_clr = 1'b0;
    at_neg();
    chk("clr_hs_total_s", int'(tot2), 0);
    chk("clr_hs_pos_s", int'(pos2), 0);
    chk("clr_hs_total_0", int'(tot0), 0);

    // Reset while holding a result.
    wait_idle();
    send_sample(14'h2093);
    wait_idle();
    res_ready = 1'b0;
    send_sample(14'h2093);
    wait_all_valid();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_hold_valid", int'(res_valid_w[0]), 0);
    chk("rst_hold_total", int'(tot0), 0);
    chk("rst_hold_core_in", int'(core_in_w[0]), 0);
    tick();
    rst_n = 1'b1;
    at_neg();
    chk("rst_hold_ready", int'(feat_ready_w[0]), 1);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      feat_valid = ($urandom_range(0, 3) != 0);
      feat_data  = 2'($urandom_range(0, 3));
      res_ready  = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 39) == 0);
      stat_clr   = ($urandom_range(0, 59) == 0);
      rst_n      = ($urandom_range(0, 1499) != 0);
      tick();
    end
    feat_valid = 1'b0;
    flush      = 1'b0;
    stat_clr   = 1'b0;
    rst_n      = 1'b1;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
